// File: rtl/mpc_rx_ctrl.sv
// rtl/mpc_rx_ctrl.sv - MPC receiver DDR demux sequencing and link qualification
//
// Holds the input demux in its all-ones set state while the receiver is
// disabled, flushes the demux pipeline on enable, qualifies the link on a
// fixed two-slice alignment pattern, then forwards registered data.
//
// Build option: MPC_RX_CHECK_EN
//   defined   - CHECK/ERR states, pattern compare, CHECK timer, err_cnt.
//   undefined - FLUSH goes straight to LOCK; rx_err and err_cnt tied to 0.
//
// Ports:
//   clock       in   40 MHz system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   enable      in   receiver enable; low forces IDLE (highest priority)
//   relock      in   one-clock pulse; restart qualification from IDLE
//   demux_set   out  1 = demux outputs forced all-ones
//   dout1st     in   demux 1st-in-time slice
//   dout2nd     in   demux 2nd-in-time slice
//   rx_data1st  out  registered 1st slice (valid with rx_valid)
//   rx_data2nd  out  registered 2nd slice (valid with rx_valid)
//   rx_valid    out  rx_data* valid, LOCK only
//   locked      out  state is LOCK
//   rx_err      out  state is ERR
//   err_cnt     out  saturating pattern mismatch count

module mpc_rx_ctrl #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] PAT1ST    = 8'hA5,
  parameter logic [WIDTH-1:0] PAT2ND    = 8'h5A,
  parameter int               NGOOD     = 4,
  parameter int               FLUSH_CYC = 3,
  parameter int               TIMEOUT   = 255
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             relock,
  output logic             demux_set,
  input  logic [WIDTH-1:0] dout1st,
  input  logic [WIDTH-1:0] dout2nd,
  output logic [WIDTH-1:0] rx_data1st,
  output logic [WIDTH-1:0] rx_data2nd,
  output logic             rx_valid,
  output logic             locked,
  output logic             rx_err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_CHECK = 3'd2,
    S_LOCK  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] flush_cnt;
  logic       flush_done;
  logic       set_d;

  assign flush_done = (flush_cnt == 3'(FLUSH_CYC - 1));

`ifdef MPC_RX_CHECK_EN
  logic [3:0] good_cnt;
  logic [7:0] timer;
  logic [7:0] err_q;
  logic       pat_match;
  logic       check_run;

  assign pat_match = ({dout1st, dout2nd} == {PAT1ST, PAT2ND});
  // Counters only advance on clocks where CHECK is not being overridden.
  assign check_run = enable && !relock && (state == S_CHECK);
  assign err_cnt   = err_q;
`else
  // Pattern/qualification parameters only feed the compare logic.
  logic unused_cfg;
  assign unused_cfg = ^{PAT1ST, PAT2ND, 8'(NGOOD), 8'(TIMEOUT)};
  assign err_cnt    = 8'h00;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; enable low beats relock, relock beats everything else
  always_comb begin
    state_nx = state;
    if (!enable || relock) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nx = S_FLUSH;
`ifdef MPC_RX_CHECK_EN
        S_FLUSH: if (flush_done) state_nx = S_CHECK;
        // The final match wins over a coincident timeout.
        S_CHECK: begin
          if (pat_match && (good_cnt == 4'(NGOOD - 1))) begin
            state_nx = S_LOCK;
          end else if (timer == 8'(TIMEOUT - 1)) begin
            state_nx = S_ERR;
          end
        end
        S_ERR:   state_nx = S_ERR;
`else
        S_FLUSH: if (flush_done) state_nx = S_LOCK;
`endif
        S_LOCK:  state_nx = S_LOCK;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    set_d  = (state == S_IDLE) || (state == S_ERR);
    locked = (state == S_LOCK);
`ifdef MPC_RX_CHECK_EN
    rx_err = (state == S_ERR);
`else
    rx_err = 1'b0;
`endif
  end

  // demux_set is registered off the current state, so it trails the state
  // change by one clock. Data forwarding keys off state_nx so rx_valid and
  // the first forwarded word coincide with entry into LOCK.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      demux_set  <= 1'b1;
      rx_valid   <= 1'b0;
      rx_data1st <= '1;
      rx_data2nd <= '1;
      flush_cnt  <= 3'd0;
    end else begin
      demux_set <= set_d;
      rx_valid  <= (state_nx == S_LOCK);
      if (state_nx == S_LOCK) begin
        rx_data1st <= dout1st;
        rx_data2nd <= dout2nd;
      end
      if (state == S_FLUSH) begin
        flush_cnt <= flush_cnt + 3'd1;
      end else begin
        flush_cnt <= 3'd0;
      end
    end
  end

`ifdef MPC_RX_CHECK_EN
  // Qualification counters; err_q survives enable=0, only relock clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      good_cnt <= 4'd0;
      timer    <= 8'd0;
      err_q    <= 8'd0;
    end else if (enable && relock) begin
      good_cnt <= 4'd0;
      timer    <= 8'd0;
      err_q    <= 8'd0;
    end else if (check_run) begin
      timer <= timer + 8'd1;
      if (pat_match) begin
        good_cnt <= good_cnt + 4'd1;
      end else begin
        good_cnt <= 4'd0;
        if (err_q != 8'hFF) begin
          err_q <= err_q + 8'd1;
        end
      end
    end else begin
      good_cnt <= 4'd0;
      timer    <= 8'd0;
    end
  end
`endif

endmodule

// File: tb/tb_mpc_rx_ctrl.sv
// tb/tb_mpc_rx_ctrl.sv - directed bench for mpc_rx_ctrl with behavioural reference model

module tb_mpc_rx_ctrl;

  localparam int NGOOD     = 4;
  localparam int FLUSH_CYC = 3;
  localparam int TIMEOUT   = 255;
`ifdef MPC_RX_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_FLUSH = 1;
  localparam int M_CHECK = 2;
  localparam int M_LOCK  = 3;
  localparam int M_ERR   = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       relock;
  logic       demux_set;
  logic [7:0] dout1st;
  logic [7:0] dout2nd;
  logic [7:0] rx_data1st;
  logic [7:0] rx_data2nd;
  logic       rx_valid;
  logic       locked;
  logic       rx_err;
  logic [7:0] err_cnt;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  mpc_rx_ctrl #(
    .WIDTH(8), .PAT1ST(8'hA5), .PAT2ND(8'h5A),
    .NGOOD(NGOOD), .FLUSH_CYC(FLUSH_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .relock(relock),
    .demux_set(demux_set), .dout1st(dout1st), .dout2nd(dout2nd),
    .rx_data1st(rx_data1st), .rx_data2nd(rx_data2nd), .rx_valid(rx_valid),
    .locked(locked), .rx_err(rx_err), .err_cnt(err_cnt)
  );

  always #5 clock = ~clock;

  // Reference model: mode plus time-in-mode, match run length and a
  // mismatch tally, advanced once per clock from the inputs at the edge.
  int         m_mode;
  int         m_next;
  int         m_age;
  int         m_run;
  int         m_errs;
  bit         m_set;
  bit         m_valid;
  bit         m_hit;
  logic [7:0] m_d1;
  logic [7:0] m_d2;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = M_IDLE; m_age = 0; m_run = 0; m_errs = 0;
      m_set = 1'b1; m_valid = 1'b0; m_d1 = 8'hFF; m_d2 = 8'hFF;
    end else begin
      m_next = m_mode;
      m_hit  = (dout1st == 8'hA5) && (dout2nd == 8'h5A);
      if (!enable || relock) begin
        m_next = M_IDLE;
        if (enable) m_errs = 0;
      end else begin
        case (m_mode)
          M_IDLE:  m_next = M_FLUSH;
          M_FLUSH: if (m_age + 1 >= FLUSH_CYC) m_next = CHK ? M_CHECK : M_LOCK;
          M_CHECK: begin
            if (m_hit) m_run = m_run + 1;
            else begin
              m_run = 0;
              if (m_errs < 255) m_errs = m_errs + 1;
            end
            if (m_run >= NGOOD) m_next = M_LOCK;
            else if (m_age + 1 >= TIMEOUT) m_next = M_ERR;
          end
          default: ;
        endcase
      end
      m_set   = (m_mode == M_IDLE) || (m_mode == M_ERR);
      m_valid = (m_next == M_LOCK);
      if (m_valid) begin
        m_d1 = dout1st;
        m_d2 = dout2nd;
      end
      m_age = (m_next == m_mode) ? m_age + 1 : 0;
      if (m_next != M_CHECK) m_run = 0;
      m_mode = m_next;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && cmp_en) begin
      chk("demux_set",  demux_set,  m_set);
      chk("locked",     locked,     m_mode == M_LOCK);
      chk("rx_err",     rx_err,     m_mode == M_ERR);
      chk("rx_valid",   rx_valid,   m_valid);
      chk("err_cnt",    err_cnt,    m_errs);
      chk("rx_data1st", rx_data1st, m_d1);
      chk("rx_data2nd", rx_data2nd, m_d2);
    end
  end

  task automatic cyc(input logic en, input logic rl, input logic [7:0] a, input logic [7:0] b);
    enable = en; relock = rl; dout1st = a; dout2nd = b;
    @(posedge clock);
    #2;
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_demux_set"}, demux_set, 1);
    chk({tag, "_locked"},    locked,    0);
    chk({tag, "_rx_valid"},  rx_valid,  0);
    chk({tag, "_rx_err"},    rx_err,    0);
    chk({tag, "_err_cnt"},   err_cnt,   0);
    chk({tag, "_rx_data1st"}, rx_data1st, 8'hFF);
    chk({tag, "_rx_data2nd"}, rx_data2nd, 8'hFF);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; relock = 1'b0; dout1st = 8'h00; dout2nd = 8'h00;
    repeat (3) @(posedge clock);
    #2;
    reset_literals("rst");
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    cyc(0, 0, 8'h00, 8'h00);
    cyc(0, 0, 8'h00, 8'h00);

`ifdef MPC_RX_CHECK_EN
    // Clean pattern: lock at clock 8
    cyc(1, 0, 8'hA5, 8'h5A);
    chk("a_set_lag", demux_set, 1);
    cyc(1, 0, 8'hA5, 8'h5A);
    chk("a_set_rel", demux_set, 0);
    repeat (5) cyc(1, 0, 8'hA5, 8'h5A);
    chk("a_clk7_unlocked", locked, 0);
    cyc(1, 0, 8'hA5, 8'h5A);
    chk("a_clk8_locked", locked, 1);
    chk("a_clk8_valid", rx_valid, 1);
    chk("a_clk8_errcnt", err_cnt, 0);
    chk("a_clk8_data", rx_data1st, 8'hA5);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 8'(i * 3 + 1), 8'(8'hF0 - i));
      chk("a_fwd1", rx_data1st, 32'(8'(i * 3 + 1)));
      chk("a_fwd2", rx_data2nd, 32'(8'(8'hF0 - i)));
    end
    cyc(0, 0, 8'h00, 8'h00);
    chk("a_drop_valid", rx_valid, 0);
    cyc(0, 0, 8'h00, 8'h00);
    chk("a_drop_set", demux_set, 1);

    // 3 good, 1 bad, 4 good
    repeat (4) cyc(1, 0, 8'h00, 8'h00);
    repeat (3) cyc(1, 0, 8'hA5, 8'h5A);
    cyc(1, 0, 8'hA5, 8'h00);
    repeat (3) cyc(1, 0, 8'hA5, 8'h5A);
    chk("b_no_lock_yet", locked, 0);
    cyc(1, 0, 8'hA5, 8'h5A);
    chk("b_lock", locked, 1);
    chk("b_errcnt", err_cnt, 1);
    repeat (2) cyc(0, 0, 8'h00, 8'h00);

    // Timeout with err_cnt saturating, then relock
    repeat (4 + 254) cyc(1, 0, 8'h00, 8'h00);
    chk("c_pre_err", rx_err, 0);
    cyc(1, 0, 8'h00, 8'h00);
    chk("c_err", rx_err, 1);
    chk("c_errcnt_sat", err_cnt, 8'hFF);
    cyc(1, 0, 8'h00, 8'h00);
    chk("c_err_set", demux_set, 1);
    repeat (3) cyc(1, 0, 8'hA5, 8'h5A);
    chk("c_err_hold", rx_err, 1);
    cyc(1, 1, 8'h00, 8'h00);
    chk("c_relock_err", rx_err, 0);
    chk("c_relock_cnt", err_cnt, 0);
    cyc(1, 0, 8'hA5, 8'h5A);
    repeat (6) cyc(1, 0, 8'hA5, 8'h5A);
    chk("c_relock_unlocked", locked, 0);
    cyc(1, 0, 8'hA5, 8'h5A);
    chk("c_relock_locked", locked, 1);

    // ERR, then enable=0 together with relock: stays IDLE
    cyc(1, 1, 8'h00, 8'h00);
    repeat (4 + 255) cyc(1, 0, 8'h00, 8'h00);
    chk("d_err", rx_err, 1);
    repeat (3) cyc(0, 1, 8'hA5, 8'h5A);
    chk("d_idle_err", rx_err, 0);
    chk("d_idle_lock", locked, 0);
    chk("d_idle_set", demux_set, 1);
    chk("d_errcnt_kept", err_cnt, 8'hFF);

    // Reach LOCK, then reset mid-cycle
    repeat (8) cyc(1, 0, 8'hA5, 8'h5A);
    chk("e_locked", locked, 1);
    cyc(1, 0, 8'h11, 8'h22);
    cyc(1, 0, 8'h33, 8'h44);
`else
    // No qualification: lock at clock 1+FLUSH_CYC with arbitrary data
    repeat (3) cyc(1, 0, 8'h12, 8'h34);
    chk("n_unlocked", locked, 0);
    cyc(1, 0, 8'h56, 8'h78);
    chk("n_locked", locked, 1);
    chk("n_valid", rx_valid, 1);
    chk("n_data1", rx_data1st, 8'h56);
    chk("n_data2", rx_data2nd, 8'h78);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 8'(i + 8'h80), 8'(8'h07 - i));
      chk("n_fwd1", rx_data1st, 32'(8'(i + 8'h80)));
      chk("n_fwd2", rx_data2nd, 32'(8'(8'h07 - i)));
    end
    cyc(1, 1, 8'h00, 8'h00);
    chk("n_relock_idle", locked, 0);
    repeat (3) cyc(1, 0, 8'h00, 8'h00);
    chk("n_relock_unlocked", locked, 0);
    cyc(1, 0, 8'h9C, 8'hC9);
    chk("n_relock_locked", locked, 1);
    chk("n_rx_err", rx_err, 0);
    chk("n_err_cnt", err_cnt, 0);
    cyc(0, 0, 8'h00, 8'h00);
    chk("n_drop_valid", rx_valid, 0);
    cyc(0, 0, 8'h00, 8'h00);
    chk("n_drop_set", demux_set, 1);
    repeat (4) cyc(1, 0, 8'h11, 8'h22);
    chk("n_locked2", locked, 1);
    cyc(1, 0, 8'h33, 8'h44);
`endif

    #1;
    reset_n = 1'b0;
    #1;
    reset_literals("async_rst");
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    repeat (3) cyc(0, 0, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mpc_rx_ctrl.md
# mpc_rx_ctrl

Sequencing controller for the MPC receiver DDR de-multiplexer. It holds the demux in its all-ones set state while the receiver is disabled and flushes the demux pipeline on enable. It qualifies the link by matching a fixed alignment pattern on the demuxed 40 MHz slices, then forwards registered data with a valid flag. It sits between the MPC input demux and the MPC frame decoder, and reports lock/error status to the VME status registers.

## Interface
- WIDTH, 8: slice width; equals demux width.
- PAT1ST, 8'hA5: expected 1st-in-time alignment slice.
- PAT2ND, 8'h5A: expected 2nd-in-time alignment slice.
- NGOOD, 4: consecutive matching words required for lock, 1..15.
- FLUSH_CYC, 3: clocks spent in FLUSH after releasing demux set, 2..7.
- TIMEOUT, 255: clocks allowed in CHECK before ERR, 1..255.

Ports:
- clock  in  1  40 MHz system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  MPC receiver enable (VME register, synchronous to clock).
- relock  in  1  single-clock pulse; restarts qualification from IDLE.
- demux_set  out  1  drives demux `set`; 1 = demux outputs forced all-ones.
- dout1st  in  WIDTH  demux 1st-in-time slice.
- dout2nd  in  WIDTH  demux 2nd-in-time slice.
- rx_data1st  out  WIDTH  registered 1st slice to decoder.
- rx_data2nd  out  WIDTH  registered 2nd slice to decoder.
- rx_valid  out  1  rx_data* valid (LOCK only).
- locked  out  1  state == LOCK.
- rx_err  out  1  state == ERR.
- err_cnt  out  8  saturating mismatch counter.

## Operation
- States: IDLE, FLUSH, CHECK, LOCK, ERR; one-hot or binary, registered.
- IDLE: demux_set=1. Go to FLUSH when enable=1 and relock=0.
- FLUSH: demux_set=0. A 3-bit counter runs for FLUSH_CYC clocks. Demux inputs are ignored. Then go to CHECK.
- CHECK: demux_set=0. Compare {dout1st,dout2nd} to {PAT1ST,PAT2ND} every clock.
  - Match: good_cnt++. A match while good_cnt==NGOOD-1 goes to LOCK.
  - Mismatch: good_cnt clears and err_cnt increments.
  - An 8-bit timer counts clocks in CHECK. Timer reaching TIMEOUT without lock goes to ERR.
- LOCK: demux_set=0. rx_data* <= dout* every clock; rx_valid=1. Pattern is no longer checked.
- ERR: demux_set=1, rx_err=1. Hold until relock or enable=0.
- From any state, enable=0 goes to IDLE; this takes priority over relock and all other transitions.
- relock=1 with enable=1 in any state goes to IDLE, clears good_cnt, timer and err_cnt. The FSM re-enters FLUSH on the next clock if relock has dropped.
- err_cnt saturates at 8'hFF. It is cleared only by reset or relock, not by enable=0.
- rx_data* hold their last value outside LOCK. rx_valid=0 outside LOCK.

## Timing
- Reset values: state=IDLE, demux_set=1, rx_data1st/2nd=all-ones, rx_valid=0, locked=0, rx_err=0, err_cnt=0, good_cnt=0, timer=0.
- reset_n assertion clears everything asynchronously, mid-operation included. Release is synchronous to clock through the existing reset synchronizer.
- demux_set is a registered state decode and changes the clock after the state change.
- The demux adds 2 clocks from set release to valid data. With FLUSH_CYC ≥ 2, no forced all-ones word reaches CHECK.
- Data latency dout* -> rx_data*: 1 clock. rx_valid rises on the same edge as the first forwarded word.
- Minimum enable -> locked: 1 (IDLE->FLUSH) + FLUSH_CYC + NGOOD clocks; 8 clocks with defaults.
- On the LOCK-exit edge, rx_valid drops in the same clock the state leaves LOCK.
- Simultaneous final match and TIMEOUT in CHECK: LOCK wins.

## Configuration
- MPC_RX_CHECK_EN defined: CHECK state, pattern compare, timer and err_cnt logic compiled in, as above.
- MPC_RX_CHECK_EN undefined:
  - FLUSH goes directly to LOCK.
  - CHECK and ERR are unreachable and removed.
  - err_cnt is tied to 0 and rx_err to 0.
  - relock still restarts IDLE->FLUSH->LOCK.

## Test plan
- Reset then enable=1, drive A5/5A continuously -> demux_set falls 1 clock after enable; locked=1 and rx_valid=1 at clock 8; err_cnt=0.
- In CHECK, drive 3 good words, 1 bad, then 4 good -> good_cnt restarts; lock on the 4th good word after the bad one; err_cnt=1.
- Drive constant 8'h00 in CHECK -> ERR after 255 clocks, demux_set=1, rx_err=1, err_cnt=8'hFF (saturated). relock -> err_cnt=0, FSM returns via FLUSH.
- In LOCK, drive incrementing data -> rx_data1st/2nd equal dout* delayed 1 clock. Drop enable -> rx_valid=0 next clock and demux_set=1.
- Assert enable=0 and relock=1 together in ERR -> IDLE and stays IDLE, since enable has priority. Assert reset_n=0 mid-LOCK -> all outputs at reset values immediately, without waiting for a clock edge.
- Build without MPC_RX_CHECK_EN, enable=1 with arbitrary data -> locked at clock 1+FLUSH_CYC; rx_err and err_cnt stay 0.
